updown_prog_mod_counter: RTL and testbench

Runtime-programmable modulo counter: the parametrised successor of the fixed modulo-N counter. It counts up or down over 0..last, where last is programmable at run time through a shadow register that commits only at a wrap boundary or a load. It supports synchronous load and produces a combinational terminal-count flag, a cascade carry and a registered wrap pulse. It serves as the timebase and prescaler primitive for dividers, baud generators and cascaded multi-digit counters in the sequential library.

---
 rtl/cnt_pkg.sv | 10 +
 rtl/updown_prog_mod_counter.sv | 58 +++++
 tb/tb_updown_prog_mod_counter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/cnt_pkg.sv
// cnt_pkg: shared constants and helpers for the counter primitives
// Exports: CNT_UP/CNT_DN direction encodings and clamp(), which returns min(value, limit).
package cnt_pkg;
    localparam logic CNT_UP = 1'b1;
    localparam logic CNT_DN = 1'b0;
    // Operands are carried at 32 bits so one helper serves every counter width.
    function automatic logic [31:0] clamp(input logic [31:0] value, input logic [31:0] limit);
        return (value > limit) ? limit : value;
    endfunction
endpackage

// File: rtl/updown_prog_mod_counter.sv
// updown_prog_mod_counter: up/down modulo counter with a shadowed, run-time programmable terminal value
// Ports: clk, rst (sync, active-high); en (step enable), up (1 = increment),
//        load/load_val (sync load), mod_wr/mod_val (write terminal value = modulus-1);
//        count, last, mod_pending, wrap (registered); tc, carry_out (combinational).
module updown_prog_mod_counter
    import cnt_pkg::*;
#(
    parameter int MAX_N    = 256,
    parameter int WIDTH    = $clog2(MAX_N),
    parameter int DEF_LAST = MAX_N - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             mod_wr,
    input  logic [WIDTH-1:0] mod_val,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] last,
    output logic             mod_pending,
    output logic             tc,
    output logic             carry_out,
    output logic             wrap
);
    logic [WIDTH-1:0] shadow, shadow_nx, last_nx, count_nx;
    logic             wrap_step, commit;

    assign tc        = (up == CNT_DN) ? (count == '0) : (count == last);
    assign carry_out = en & tc;
    assign wrap_step = carry_out & ~load;
    // last only moves at load or wrap, which keeps count inside 0..last.
    assign commit    = load | wrap_step;
    // A write in this cycle is what gets committed if a commit also happens now.
    assign shadow_nx = mod_wr ? WIDTH'(clamp(32'(mod_val), 32'(MAX_N - 1))) : shadow;
    assign last_nx   = commit ? shadow_nx : last;
    assign count_nx  = load ? WIDTH'(clamp(32'(load_val), 32'(last_nx))) :
                       !en ? count :
                       (up == CNT_UP) ? (tc ? '0 : count + WIDTH'(1)) :
                       (tc ? last_nx : count - WIDTH'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count       <= '0;
            last        <= WIDTH'(DEF_LAST);
            shadow      <= WIDTH'(DEF_LAST);
            mod_pending <= 1'b0;
            wrap        <= 1'b0;
        end else begin
            count       <= count_nx;
            last        <= last_nx;
            shadow      <= shadow_nx;
            mod_pending <= ~commit & (mod_pending | mod_wr);
            wrap        <= wrap_step;
        end
    end
endmodule

// File: tb/tb_updown_prog_mod_counter.sv
// tb_updown_prog_mod_counter: directed vector table plus multi-cycle sequences for the counter
module tb_updown_prog_mod_counter;
    logic       clk = 1'b0;
    logic       rst, en, up, load, mod_wr;
    logic [7:0] load_val, mod_val, count, last;
    logic       mod_pending, tc, carry_out, wrap;

    logic       c_rst, c_en, c_up, c_load, c_mw;
    logic [7:0] c_lv, c_mv, c0_count, c0_last, c1_count, c1_last;
    logic       c0_pend, c0_tc, c0_carry, c0_wrap, c1_pend, c1_tc, c1_carry, c1_wrap;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    updown_prog_mod_counter #(.MAX_N(256)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_val(load_val),
        .mod_wr(mod_wr), .mod_val(mod_val), .count(count), .last(last),
        .mod_pending(mod_pending), .tc(tc), .carry_out(carry_out), .wrap(wrap)
    );

    updown_prog_mod_counter #(.MAX_N(256)) stage0 (
        .clk(clk), .rst(c_rst), .en(c_en), .up(c_up), .load(c_load), .load_val(c_lv),
        .mod_wr(c_mw), .mod_val(c_mv), .count(c0_count), .last(c0_last),
        .mod_pending(c0_pend), .tc(c0_tc), .carry_out(c0_carry), .wrap(c0_wrap)
    );

    updown_prog_mod_counter #(.MAX_N(256)) stage1 (
        .clk(clk), .rst(c_rst), .en(c0_carry), .up(c_up), .load(c_load), .load_val(c_lv),
        .mod_wr(c_mw), .mod_val(c_mv), .count(c1_count), .last(c1_last),
        .mod_pending(c1_pend), .tc(c1_tc), .carry_out(c1_carry), .wrap(c1_wrap)
    );

    typedef struct {
        logic       rst, en, up, load;
        logic [7:0] lv;
        logic       mw;
        logic [7:0] mv;
        logic [7:0] c, l;
        logic       p, w, t;
    } vec_t;

    vec_t v[20];

    int mc, ml, ms, mp, mw;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_step(input logic do_mw, input logic [7:0] mv);
        rst = 0; en = 1; up = 1; load = 0; load_val = 0;
        mod_wr = do_mw; mod_val = mv;
        if (do_mw) begin
            ms = mv;
            mp = 1;
        end
        tick();
        if (mc == ml) begin
            mc = 0; ml = ms; mp = 0; mw = 1;
        end else begin
            mc = mc + 1; mw = 0;
        end
        chk("seq_count", count, mc);
        chk("seq_last", last, ml);
        chk("seq_pending", mod_pending, mp);
        chk("seq_wrap", wrap, mw);
        chk("seq_tc", tc, int'(mc == ml));
    endtask

    initial begin
        rst = 1; en = 0; up = 1; load = 0; load_val = 0; mod_wr = 0; mod_val = 0;
        c_rst = 1; c_en = 0; c_up = 1; c_load = 0; c_lv = 0; c_mw = 0; c_mv = 0;

        v[0]  = '{1,0,1,0,  0,0, 0,   0,255,0,0,0};
        v[1]  = '{0,1,1,1,200,0, 0, 200,255,0,0,0};
        v[2]  = '{0,0,1,1,255,0, 0, 255,255,0,0,1};
        v[3]  = '{0,1,1,0,  0,0, 0,   0,255,0,1,0};
        v[4]  = '{0,0,0,0,  0,0, 0,   0,255,0,0,1};
        v[5]  = '{0,1,0,0,  0,0, 0, 255,255,0,1,0};
        v[6]  = '{0,1,0,0,  0,0, 0, 254,255,0,0,0};
        v[7]  = '{0,1,0,0,  0,1, 9, 253,255,1,0,0};
        v[8]  = '{0,0,0,0,  0,1,12, 253,255,1,0,0};
        v[9]  = '{0,1,1,1,200,0, 0,  12, 12,0,0,1};
        v[10] = '{0,1,1,0,  0,0, 0,   0, 12,0,1,0};
        v[11] = '{0,1,0,0,  0,1, 4,   4,  4,0,1,0};
        v[12] = '{0,1,1,1,  7,1, 3,   3,  3,0,0,1};
        v[13] = '{1,0,1,1,  5,0, 0,   0,255,0,0,0};
        v[14] = '{0,1,1,0,  0,1, 0,   1,255,1,0,0};
        v[15] = '{0,0,1,1,  0,0, 0,   0,  0,0,0,1};
        v[16] = '{0,1,1,0,  0,0, 0,   0,  0,0,1,1};
        v[17] = '{0,1,0,0,  0,0, 0,   0,  0,0,1,1};
        v[18] = '{0,0,1,0,  0,1, 5,   0,  0,1,0,1};
        v[19] = '{1,0,1,0,  0,0, 0,   0,255,0,0,0};

        for (int i = 0; i < 20; i++) begin
            rst = v[i].rst; en = v[i].en; up = v[i].up; load = v[i].load;
            load_val = v[i].lv; mod_wr = v[i].mw; mod_val = v[i].mv;
            tick();
            chk($sformatf("vec%0d_count", i), count, v[i].c);
            chk($sformatf("vec%0d_last", i), last, v[i].l);
            chk($sformatf("vec%0d_pending", i), mod_pending, v[i].p);
            chk($sformatf("vec%0d_wrap", i), wrap, v[i].w);
            chk($sformatf("vec%0d_tc", i), tc, v[i].t);
            chk($sformatf("vec%0d_carry", i), carry_out, int'(v[i].en & v[i].t));
        end

        rst = 1; en = 0; load = 0; mod_wr = 0;
        tick();
        mc = 0; ml = 255; ms = 255; mp = 0; mw = 0;
        chk("reset_count", count, 0);
        for (int i = 0; i < 356; i++) model_step(0, 0);
        chk("at_100", count, 100);
        model_step(1, 9);
        chk("deferred_pending", mod_pending, 1);
        for (int i = 0; i < 180; i++) model_step(0, 0);
        chk("deferred_last", last, 9);

        c_rst = 0; c_load = 1; c_lv = 0; c_mw = 1; c_mv = 9;
        tick();
        c_load = 0; c_mw = 0;
        chk("casc_last0", c0_last, 9);
        chk("casc_last1", c1_last, 9);
        c_en = 1;
        for (int i = 1; i <= 250; i++) begin
            tick();
            chk("casc_stage0", c0_count, i % 10);
            chk("casc_stage1", c1_count, (i / 10) % 10);
        end
        chk("casc_carry0", c0_carry, 1'b0);
        c_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
